// File: rtl/per_sft_rst_sel_seq.sv
// rtl/per_sft_rst_sel_seq.sv - software-reset pulse shaper and safe-point kernel-clock-select applier
module per_sft_rst_sel_seq #(
    parameter int KER_CLK_SRC_NUM = 5,
    parameter int SEL_W           = ($clog2(KER_CLK_SRC_NUM) > 1) ? $clog2(KER_CLK_SRC_NUM) : 1,
    parameter int SEL_RST_VAL     = 0,
    parameter int MIN_RST_CYCLES  = 4,
    parameter int RELEASE_DELAY   = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             rcc_per_rst,
    input  logic [SEL_W-1:0] ker_clk_sel_wr,
    input  logic             per_ker_clk_req,
    output logic             sft_rst_n,
    output logic [SEL_W-1:0] ker_clk_sel,
    output logic             sel_pending,
    output logic             sel_invalid,
    output logic             rst_busy,
    output logic             rst_done
);

    localparam int CNT_MAX = (MIN_RST_CYCLES > RELEASE_DELAY) ? MIN_RST_CYCLES : RELEASE_DELAY;
    localparam int CNT_W   = ($clog2(CNT_MAX) > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] ASSERT_LOAD  = CNT_W'(MIN_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_LOAD = CNT_W'(RELEASE_DELAY - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             done_nxt;
    logic             sel_safe;
    logic [SEL_W-1:0] sel_nxt;

    assign sel_invalid = 32'(ker_clk_sel_wr) >= $unsigned(KER_CLK_SRC_NUM);
    assign sel_pending = ker_clk_sel_wr != ker_clk_sel;

    // Switching the kernel clock mux is harmless while the peripheral is in reset or not using it
    assign sel_safe = (state == ASSERT) || (state == HOLD) ||
                      ((state == IDLE) && !per_ker_clk_req);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (rcc_per_rst) begin
                    state_nxt = ASSERT;
                    cnt_nxt   = ASSERT_LOAD;
                end
            end
            ASSERT: begin
                if (cnt == '0) begin
                    if (rcc_per_rst) begin
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = RELEASE;
                        cnt_nxt   = RELEASE_LOAD;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            HOLD: begin
                if (!rcc_per_rst) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = RELEASE_LOAD;
                end
            end
            RELEASE: begin
                // A fresh request during settle restarts the whole pulse
                if (rcc_per_rst) begin
                    state_nxt = ASSERT;
                    cnt_nxt   = ASSERT_LOAD;
                end else if (cnt == '0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        sel_nxt = ker_clk_sel;
        if (sel_safe && !sel_invalid && sel_pending) begin
            sel_nxt = ker_clk_sel_wr;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            sft_rst_n   <= 1'b1;
            ker_clk_sel <= SEL_W'(SEL_RST_VAL);
            rst_busy    <= 1'b0;
            rst_done    <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            sft_rst_n   <= !((state_nxt == ASSERT) || (state_nxt == HOLD));
            ker_clk_sel <= sel_nxt;
            rst_busy    <= state_nxt != IDLE;
            rst_done    <= done_nxt;
        end
    end

endmodule

// File: tb/tb_per_sft_rst_sel_seq.sv
// tb/tb_per_sft_rst_sel_seq.sv - self-checking bench for per_sft_rst_sel_seq
module tb_per_sft_rst_sel_seq;

    localparam int NUM = 5;
    localparam int MINC = 4;
    localparam int RELD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rcc = 1'b0;
    logic [2:0] wr  = 3'd0;
    logic       req = 1'b0;
    logic       sft_rst_n;
    logic [2:0] sel;
    logic       pending;
    logic       invalid;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: 0 = idle, 1 = reset driven low, 2 = settling after release
    int         m_ph;
    int         m_n_low;
    int         m_n_rel;
    logic [2:0] m_sel;
    logic       m_done;

    always #5 clk = ~clk;

    per_sft_rst_sel_seq #(
        .KER_CLK_SRC_NUM(NUM),
        .SEL_W(3),
        .SEL_RST_VAL(0),
        .MIN_RST_CYCLES(MINC),
        .RELEASE_DELAY(RELD)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .rcc_per_rst(rcc),
        .ker_clk_sel_wr(wr),
        .per_ker_clk_req(req),
        .sft_rst_n(sft_rst_n),
        .ker_clk_sel(sel),
        .sel_pending(pending),
        .sel_invalid(invalid),
        .rst_busy(busy),
        .rst_done(done)
    );

    task automatic model_reset();
        m_ph = 0; m_n_low = 0; m_n_rel = 0; m_sel = 3'd0; m_done = 1'b0;
    endtask

    task automatic tick();
        logic r;
        logic safe;
        r    = rcc;
        safe = (m_ph == 1) || (m_ph == 0 && !req);
        @(posedge clk);
        #1;
        m_done = 1'b0;
        if (safe && wr < NUM && wr != m_sel) m_sel = wr;
        if (m_ph == 0) begin
            if (r) begin m_ph = 1; m_n_low = 0; end
        end else if (m_ph == 1) begin
            m_n_low++;
            if (m_n_low >= MINC && !r) begin m_ph = 2; m_n_rel = 0; end
        end else begin
            if (r) begin
                m_ph = 1; m_n_low = 0;
            end else begin
                m_n_rel++;
                if (m_n_rel >= RELD) begin m_ph = 0; m_done = 1'b1; end
            end
        end
    endtask

    task automatic test_reset();
        #12 rst = 1'b1;
        #1;
        model_reset();
        n_tests++; if (sft_rst_n !== 1'b1) begin n_fail++; $display("FAIL reset_sft_rst_n got %b exp 1", sft_rst_n); end
        n_tests++; if (sel !== 3'd0) begin n_fail++; $display("FAIL reset_sel got %0d exp 0", sel); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_tests++;
            if ({sft_rst_n, sel, busy, done} !== {1'b1, 3'd0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_idle c=%0d got n=%b sel=%0d busy=%b done=%b exp 1 0 0 0", c, sft_rst_n, sel, busy, done);
            end
        end
    endtask

    task automatic test_short_pulse();
        rcc = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 1) rcc = 1'b0;
            n_tests++;
            if (sft_rst_n !== !(c >= 1 && c <= 4) || busy !== (c <= 6) || done !== (c == 7)) begin
                n_fail++;
                $display("FAIL short_pulse c=%0d got n=%b busy=%b done=%b exp %b %b %b",
                         c, sft_rst_n, busy, done, !(c <= 4), (c <= 6), (c == 7));
            end
        end
    endtask

    task automatic test_hold();
        int lows = 0;
        int dones = 0;
        rcc = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c == 10) rcc = 1'b0;
            if (!sft_rst_n) lows++;
            if (done) dones++;
            n_tests++;
            if (sft_rst_n !== !(c <= 10) || busy !== (c <= 12) || done !== (c == 13)) begin
                n_fail++;
                $display("FAIL hold c=%0d got n=%b busy=%b done=%b exp %b %b %b",
                         c, sft_rst_n, busy, done, !(c <= 10), (c <= 12), (c == 13));
            end
        end
        n_tests++; if (lows != 10) begin n_fail++; $display("FAIL hold_low_count got %0d exp 10", lows); end
        n_tests++; if (dones != 1) begin n_fail++; $display("FAIL hold_done_count got %0d exp 1", dones); end
    endtask

    task automatic test_sel_blocked();
        req = 1'b1; wr = 3'd2;
        #1;
        n_tests++; if (pending !== 1'b1 || sel !== 3'd0) begin n_fail++; $display("FAIL sel_block_pre got p=%b sel=%0d exp 1 0", pending, sel); end
        tick(); tick();
        n_tests++; if (sel !== 3'd0 || pending !== 1'b1) begin n_fail++; $display("FAIL sel_blocked got sel=%0d p=%b exp 0 1", sel, pending); end
        req = 1'b0;
        tick();
        n_tests++; if (sel !== 3'd2 || pending !== 1'b0) begin n_fail++; $display("FAIL sel_unblock got sel=%0d p=%b exp 2 0", sel, pending); end
        req = 1'b1; wr = 3'd4;
        tick();
        n_tests++; if (sel !== 3'd2 || pending !== 1'b1) begin n_fail++; $display("FAIL sel_blocked2 got sel=%0d p=%b exp 2 1", sel, pending); end
        rcc = 1'b1;
        tick();
        rcc = 1'b0;
        n_tests++; if (sel !== 3'd2) begin n_fail++; $display("FAIL sel_assert_c1 got %0d exp 2", sel); end
        tick();
        n_tests++; if (sel !== 3'd4 || pending !== 1'b0) begin n_fail++; $display("FAIL sel_in_assert got sel=%0d p=%b exp 4 0", sel, pending); end
        for (int c = 0; c < 6; c++) tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sel_seq_end got busy=%b exp 0", busy); end
    endtask

    task automatic test_sel_invalid();
        req = 1'b0; wr = 3'd5;
        #1;
        n_tests++; if (invalid !== 1'b1 || pending !== 1'b1) begin n_fail++; $display("FAIL inv5_flags got i=%b p=%b exp 1 1", invalid, pending); end
        tick();
        n_tests++; if (sel !== 3'd4) begin n_fail++; $display("FAIL inv5_sel got %0d exp 4", sel); end
        wr = 3'd7;
        #1;
        n_tests++; if (invalid !== 1'b1) begin n_fail++; $display("FAIL inv7_flag got %b exp 1", invalid); end
        tick();
        n_tests++; if (sel !== 3'd4 || pending !== 1'b1) begin n_fail++; $display("FAIL inv7_sel got sel=%0d p=%b exp 4 1", sel, pending); end
        wr = 3'd3;
        tick();
        n_tests++; if (sel !== 3'd3 || pending !== 1'b0 || invalid !== 1'b0) begin n_fail++; $display("FAIL valid3 got sel=%0d p=%b i=%b exp 3 0 0", sel, pending, invalid); end
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        rcc = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 1) rcc = 1'b0;
            if (c == 5) rcc = 1'b1;
            if (c == 6) rcc = 1'b0;
            if (done) dones++;
            n_tests++;
            if (sft_rst_n !== !((c <= 4) || (c >= 6 && c <= 9)) || busy !== (c <= 11) || done !== (c == 12)) begin
                n_fail++;
                $display("FAIL restart c=%0d got n=%b busy=%b done=%b", c, sft_rst_n, busy, done);
            end
        end
        n_tests++; if (dones != 1) begin n_fail++; $display("FAIL restart_done_count got %0d exp 1", dones); end
        rcc = 1'b1;
        tick();
        rcc = 1'b0;
        tick();
        n_tests++; if (sft_rst_n !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL pre_abort got n=%b busy=%b exp 0 1", sft_rst_n, busy); end
        #3 rst = 1'b1;
        #1;
        model_reset();
        n_tests++;
        if ({sft_rst_n, busy, done, sel} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL abort got n=%b busy=%b done=%b sel=%0d exp 1 0 0 0", sft_rst_n, busy, done, sel);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_tests++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_after c=%0d got done=%b busy=%b exp 0 0", c, done, busy); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 7) == 0) rcc = ~rcc;
            if ($urandom_range(0, 4) == 0) req = ~req;
            if ($urandom_range(0, 5) == 0) wr = 3'($urandom_range(0, 7));
            tick();
            n_tests++;
            if (sft_rst_n !== (m_ph != 1) || busy !== (m_ph != 0) || done !== m_done || sel !== m_sel ||
                pending !== (wr != m_sel) || invalid !== (wr >= NUM)) begin
                n_fail++;
                $display("FAIL random c=%0d got n=%b b=%b d=%b sel=%0d p=%b i=%b exp %b %b %b %0d %b %b",
                         c, sft_rst_n, busy, done, sel, pending, invalid,
                         (m_ph != 1), (m_ph != 0), m_done, m_sel, (wr != m_sel), (wr >= NUM));
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_short_pulse();
        test_hold();
        test_sel_blocked();
        test_sel_invalid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
